// File: rtl/ascii_pkg.sv
// Shared ASCII definitions for the Random Number Game message reader and writer.
// Contents: parser state enum, character constants, byte classification helpers.
package ascii_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    CAPT = 3'd2,
    EVAL = 3'd3,
    ECHO = 3'd4
  } ascii_state_e;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/ascii_dec_accum.sv
// Decimal line accumulator: acc = acc*10 + digit with length and range checks.
// Ports: clk, reset_n (async, active-low); digit/load add a digit, bad marks the
// line rejected, clear starts a new line (highest priority); acc/ndig/err are the
// line state; active_next_c is the combinational "line partially received" value
// the state will hold after this edge.
module ascii_dec_accum #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned W          = 14,
  localparam int unsigned NDW       = $clog2(MAX_DIGITS + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [3:0]     digit,
  input  logic           load,
  input  logic           bad,
  input  logic           clear,
  output logic [W-1:0]   acc,
  output logic [NDW-1:0] ndig,
  output logic           err,
  output logic           active_next_c
);

  localparam int unsigned XW = W + 4;

  logic [XW-1:0]  prod;
  logic [W-1:0]   acc_d;
  logic [NDW-1:0] ndig_d;
  logic           err_d;

  // x10 as shift-add; W+4 bits hold (2^W-1)*10+9 without wrapping
  always_comb begin
    prod          = (XW'(acc) << 3) + (XW'(acc) << 1) + XW'(digit);
    acc_d         = acc;
    ndig_d        = ndig;
    err_d         = err;
    if (clear) begin
      acc_d  = '0;
      ndig_d = '0;
      err_d  = 1'b0;
    end else if (bad) begin
      err_d = 1'b1;
    end else if (load && !err) begin
      if ((ndig == NDW'(MAX_DIGITS)) || (prod[XW-1:W] != '0)) begin
        err_d = 1'b1;
      end else begin
        acc_d  = prod[W-1:0];
        ndig_d = ndig + NDW'(1);
      end
    end
    active_next_c = (ndig_d != '0) || err_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      ndig <= '0;
      err  <= 1'b0;
    end else begin
      acc  <= acc_d;
      ndig <= ndig_d;
      err  <= err_d;
    end
  end

endmodule

// File: rtl/ascii_rx_parser.sv
// Drains the UART RX FIFO and parses CR/LF-terminated decimal lines into guesses.
// Ports: clk, reset_n (async, active-low); rx_empty/rx_data/rd_en FIFO read side;
// guess + guess_valid strobe or parse_err strobe per terminated line; busy while
// a byte is in flight or a line is partially received.
// Optional ASCII_ECHO_EN: adds tx_full/tx_data/tx_wr_en and echoes every byte.
module ascii_rx_parser
  import ascii_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned W          = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rx_empty,
  input  logic [7:0]   rx_data,
`ifdef ASCII_ECHO_EN
  input  logic         tx_full,
  output logic [7:0]   tx_data,
  output logic         tx_wr_en,
`endif
  output logic         rd_en,
  output logic [W-1:0] guess,
  output logic         guess_valid,
  output logic         parse_err,
  output logic         busy
);

  localparam int unsigned NDW = $clog2(MAX_DIGITS + 1);

  ascii_state_e   state, state_d;
  logic [7:0]     byte_q, byte_d;
  logic [W-1:0]   guess_d;
  logic           rd_en_d, gv_d, perr_d, busy_d;
  logic           acc_load, acc_bad, acc_clear, line_active_c;
  logic [W-1:0]   acc;
  logic [NDW-1:0] ndig;
  logic           err;
`ifdef ASCII_ECHO_EN
  logic [7:0]     tx_data_d;
  logic           tx_wr_en_d;
`endif

  ascii_dec_accum #(.MAX_DIGITS(MAX_DIGITS), .W(W)) u_accum (
    .clk           (clk),
    .reset_n       (reset_n),
    .digit         (byte_q[3:0]),
    .load          (acc_load),
    .bad           (acc_bad),
    .clear         (acc_clear),
    .acc           (acc),
    .ndig          (ndig),
    .err           (err),
    .active_next_c (line_active_c)
  );

  // Next state, accumulator control and next values of the registered outputs
  always_comb begin
    state_d    = state;
    byte_d     = byte_q;
    guess_d    = guess;
    gv_d       = 1'b0;
    perr_d     = 1'b0;
    acc_load   = 1'b0;
    acc_bad    = 1'b0;
    acc_clear  = 1'b0;
`ifdef ASCII_ECHO_EN
    tx_data_d  = tx_data;
    tx_wr_en_d = 1'b0;
`endif
    case (state)
      IDLE: if (!rx_empty) state_d = POP;
      POP:  state_d = CAPT;
      CAPT: begin
        byte_d  = rx_data;
        state_d = EVAL;
      end
      EVAL: begin
        if (is_term(byte_q)) begin
          // Empty line (e.g. LF after CR) produces no strobe
          acc_clear = 1'b1;
          if (err) begin
            perr_d = 1'b1;
          end else if (ndig != '0) begin
            gv_d    = 1'b1;
            guess_d = acc;
          end
        end else if (is_digit(byte_q)) begin
          acc_load = 1'b1;
        end else begin
          acc_bad = 1'b1;
        end
`ifdef ASCII_ECHO_EN
        state_d = ECHO;
`else
        state_d = IDLE;
`endif
      end
`ifdef ASCII_ECHO_EN
      ECHO: begin
        if (!tx_full) begin
          tx_wr_en_d = 1'b1;
          tx_data_d  = byte_q;
          state_d    = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    rd_en_d = (state_d == POP);
    busy_d  = (state_d != IDLE) || line_active_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      byte_q      <= '0;
      guess       <= '0;
      rd_en       <= 1'b0;
      guess_valid <= 1'b0;
      parse_err   <= 1'b0;
      busy        <= 1'b0;
`ifdef ASCII_ECHO_EN
      tx_data     <= '0;
      tx_wr_en    <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      byte_q      <= byte_d;
      guess       <= guess_d;
      rd_en       <= rd_en_d;
      guess_valid <= gv_d;
      parse_err   <= perr_d;
      busy        <= busy_d;
`ifdef ASCII_ECHO_EN
      tx_data     <= tx_data_d;
      tx_wr_en    <= tx_wr_en_d;
`endif
    end
  end

endmodule

// File: doc/ascii_rx_parser.md
# ascii_rx_parser

Reader-side counterpart to the ASCII message writer in the Random Number Game. It drains bytes from the UART receive FIFO and parses decimal ASCII digits into a binary guess value. Each line ends with CR or LF. The block presents either a one-cycle `guess_valid` strobe with the value, or a one-cycle `parse_err` strobe, to the game controller.

## Interface
Parameters:
- `MAX_DIGITS`, default 4: maximum accepted digits per line.
- `W`, default 14: width of the `guess` output. Values above 2^W−1 are errors.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `rx_empty`, in, 1: RX FIFO empty flag.
- `rx_data`, in, 8: RX FIFO read data. Valid the cycle after `rd_en`.
- `rd_en`, out, 1: RX FIFO pop, one cycle per byte.
- `guess`, out, W: parsed value. Held until the next `guess_valid`.
- `guess_valid`, out, 1: one-cycle strobe; `guess` is new.
- `parse_err`, out, 1: one-cycle strobe; the line was rejected.
- `busy`, out, 1: high whenever the state is not IDLE or a line is partially received (digit count ≠ 0 or error flag set).

## Operation
- States:
  - **IDLE:** if `!rx_empty`, go to POP.
  - **POP:** `rd_en`=1, go to CAPT.
  - **CAPT:** register `rx_data` into `byte_q`, go to EVAL.
  - **EVAL:** classify `byte_q`, update the line state, go to IDLE (ECHO when `ASCII_ECHO_EN`).
- Classification in EVAL:
  - **Digit (0x30–0x39), err flag clear:**
    - `acc` ← `acc`·10 + (`byte_q`−0x30), computed as (`acc`<<3)+(`acc`<<1)+d in W+4 bits.
    - `ndig`++.
    - Set err if `ndig` would exceed `MAX_DIGITS` or the result exceeds 2^W−1.
  - **Terminator (0x0D or 0x0A):**
    - err set: pulse `parse_err`.
    - `ndig`>0: `guess` ← `acc[W-1:0]`, pulse `guess_valid`.
    - `ndig`=0 and no err: ignored, so CR+LF yields exactly one result.
    - Then clear `acc`, `ndig` and err.
  - **Any other byte:** set err. Subsequent bytes are discarded until a terminator.
- Only one of `guess_valid` and `parse_err` fires per terminator. Neither fires without a terminator.
- Leading zeros count toward `MAX_DIGITS`.
- Reset mid-line: all state is cleared and partial digits are lost.
- Reset values:
  - `rd_en`, `guess_valid`, `parse_err`, `busy`: 0.
  - `guess`: 0.
  - `acc`, `ndig`, err: 0.
  - State: IDLE.

## Timing
- One byte is consumed per 4 cycles (IDLE→POP→CAPT→EVAL). `rd_en` is never asserted on consecutive cycles.
- `rd_en` is a Moore output of POP. It is asserted only when `rx_empty` was low in the preceding IDLE cycle.
- Latency, with cycle 0 being IDLE with `rx_empty`=0 and the byte a terminator:
  - cycle 1: POP.
  - cycle 2: CAPT.
  - cycle 3: EVAL.
  - cycle 4: `guess_valid`/`parse_err` high.
- Strobes are registered and high for exactly one cycle.
- `rx_empty` rising during POP/CAPT/EVAL has no effect on the byte in flight.

## Configuration
- `ASCII_ECHO_EN` defined:
  - Adds ports `tx_full` (in, 1), `tx_data` (out, 8) and `tx_wr_en` (out, 1).
  - Adds state ECHO after EVAL. ECHO waits while `tx_full`=1, then asserts `tx_wr_en` for one cycle with `tx_data`=`byte_q`, then returns to IDLE.
  - Every byte is echoed, including rejected ones.
  - Throughput drops to 5 cycles per byte when `tx_full`=0.
  - Reset values: `tx_wr_en`=0, `tx_data`=0.
- `ASCII_ECHO_EN` undefined: the echo ports and the ECHO state do not exist, and EVAL→IDLE directly.

## Structure
- Shared package `ascii_pkg`:
  - State enum.
  - Constants `ASCII_0`=0x30, `ASCII_9`=0x39, `ASCII_CR`=0x0D, `ASCII_LF`=0x0A.
  - This package is also used by the message writer.
- One sub-module, `ascii_dec_accum`:
  - Holds `acc`, `ndig` and the err flag.
  - Inputs: digit, load strobe, clear.
  - Computes ×10+d and the overflow/length checks.
  - The FSM stays in the top module.

## Test plan
- FIFO holds "42\r" → three pops; `guess`=42 with one `guess_valid`; no `parse_err`.
- "1234\r\n" → single `guess_valid`, `guess`=1234; LF produces no strobe.
- "12345\r" (MAX_DIGITS=4) → `parse_err` once, no `guess_valid`. A following "7\n" gives `guess`=7.
- "9999\r" with W=13 → `parse_err` (9999 > 8191). "8191\r" → `guess`=8191.
- "4x2\r" → `parse_err`. Assert `reset_n` low after "56" mid-line, then send "3\r" → `guess`=3.
- With `ASCII_ECHO_EN`: "5\r" with `tx_full` held high 10 cycles → no `tx_wr_en` while full. Then `tx_data`=0x35 then 0x0D, one `tx_wr_en` each, and `guess`=5.
